// File: rtl/generic_bus_ram_responder.sv
// Word-organised, byte-enabled RAM responder for generic_bus_if.
// Inserts LATENCY wait states through busy before each access completes.
module generic_bus_ram_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        error,
    output logic [1:0]  dbg_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT      = 4'(LATENCY);
    localparam bit         LAT_ZERO = (LATENCY == 0);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          cap_load;
    logic [29:0]   cap_addr;
    logic          cap_ren, cap_wen;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          changed;
    logic          complete;
    logic [29:0]   comp_hi;
    logic          comp_wen;
    logic          comp_oor;
    logic [AW-1:0] comp_idx;
    logic [31:0]   rd_word;
    logic          do_write;
    logic          unused_lsbs;

    assign req         = ren | wen;
    assign changed     = (addr[31:2] != cap_addr) || (ren != cap_ren) || (wen != cap_wen);
    assign unused_lsbs = ^addr[1:0];

    // State register plus captured request and read-data holding register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            cap_addr <= 30'd0;
            cap_ren  <= 1'b0;
            cap_wen  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (cap_load) begin
                cap_addr <= addr[31:2];
                cap_ren  <= ren;
                cap_wen  <= wen;
            end
            if (complete) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Next-state logic; a changed request in WAIT restarts the count
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cap_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req && !LAT_ZERO) begin
                    cap_load = 1'b1;
                    cnt_n    = 4'd1;
                    state_n  = LAT_ONE ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    cnt_n   = 4'd0;
                    state_n = S_IDLE;
                end else if (changed) begin
                    cap_load = 1'b1;
                    cnt_n    = 4'd1;
                    state_n  = LAT_ONE ? S_DONE : S_WAIT;
                end else begin
                    cnt_n = cnt + 4'd1;
                    if (cnt + 4'd1 == LAT) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_n   = 4'd0;
                state_n = S_IDLE;
            end
            default: begin
                cnt_n   = 4'd0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs; with zero latency the live request is serviced directly
    always_comb begin
        complete = 1'b0;
        comp_hi  = cap_addr;
        comp_wen = cap_wen;
        if (LAT_ZERO) begin
            complete = nRST && (state == S_IDLE) && req;
            comp_hi  = addr[31:2];
            comp_wen = wen;
        end else begin
            complete = (state == S_DONE);
        end
        comp_oor = |comp_hi[29:AW];
        comp_idx = comp_hi[AW-1:0];
        rd_word  = comp_oor ? 32'd0 : mem[comp_idx];
        do_write = complete && comp_wen && !comp_oor;
        busy     = !complete;
        error    = complete && comp_oor;
        rdata    = complete ? rd_word : rdata_q;
    end

    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[comp_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: three instances (latency 2, 0, 3) driven by
// a directed vector table plus hand-written wait-state, restart and reset sequences.
module tb_generic_bus_ram_responder;

    localparam int DEPTH = 64;

    logic        CLK;
    logic        nRST;
    logic        ren_s   [3];
    logic        wen_s   [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  be_s    [3];
    logic [31:0] rdata_s [3];
    logic        busy_s  [3];
    logic        error_s [3];
    logic [1:0]  dbg_s   [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    generic_bus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
        .CLK(CLK), .nRST(nRST), .ren(ren_s[0]), .wen(wen_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .byte_en(be_s[0]), .rdata(rdata_s[0]), .busy(busy_s[0]),
        .error(error_s[0]), .dbg_state(dbg_s[0])
    );
    generic_bus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
        .CLK(CLK), .nRST(nRST), .ren(ren_s[1]), .wen(wen_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .byte_en(be_s[1]), .rdata(rdata_s[1]), .busy(busy_s[1]),
        .error(error_s[1]), .dbg_state(dbg_s[1])
    );
    generic_bus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
        .CLK(CLK), .nRST(nRST), .ren(ren_s[2]), .wen(wen_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .byte_en(be_s[2]), .rdata(rdata_s[2]), .busy(busy_s[2]),
        .error(error_s[2]), .dbg_state(dbg_s[2])
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          dut;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int d, input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input bit chk,
                                input logic [31:0] er, input bit ee);
        vec_t v;
        v.dut = d; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.be = be;
        v.chk_rd = chk; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // driver: call at posedge+1, holds the request until completion then drops it
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, output int nbusy,
                          output logic [31:0] got_rd, output logic got_err);
        bit done;
        ren_s[d] = rd; wen_s[d] = wr; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = be;
        nbusy = 0; got_rd = '0; got_err = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (!busy_s[d]) begin
                got_rd  = rdata_s[d];
                got_err = error_s[d];
                done    = 1'b1;
            end else begin
                nbusy++;
            end
        end
        if (!done) nbusy = -1;
        @(posedge CLK); #1;
        ren_s[d] = 1'b0; wen_s[d] = 1'b0;
    endtask

    initial begin
        int          nb;
        logic [31:0] gr;
        logic        ge;
        int          comp;

        for (int d = 0; d < 3; d++) begin
            ren_s[d] = 0; wen_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0; be_s[d] = 0;
        end
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset busy d%0d", d), 32'(busy_s[d]), 32'd1);
            check($sformatf("reset rdata d%0d", d), rdata_s[d], 32'd0);
            check($sformatf("reset error d%0d", d), 32'(error_s[d]), 32'd0);
            check($sformatf("reset state d%0d", d), 32'(dbg_s[d]), 32'd0);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // dut, rd, wr, addr, wdata, byte_en, check rdata, expected rdata, expected error
        vecs.push_back(mk(0, 0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h10,  32'h0,        4'h0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 1, 32'h20,  32'h11223344, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h20,  32'hAABBCCDD, 4'h5, 1, 32'h11223344, 0));
        vecs.push_back(mk(0, 1, 0, 32'h20,  32'h0,        4'h0, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(0, 0, 1, 32'h20,  32'h000000EE, 4'h1, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(0, 1, 0, 32'h22,  32'h0,        4'h0, 1, 32'h11BB33EE, 0));
        vecs.push_back(mk(0, 0, 1, 32'h30,  32'hCAFEF00D, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   32'h12345678, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,   32'h0,        4'h0, 1, 32'h12345678, 0));
        vecs.push_back(mk(0, 1, 0, 32'h124, 32'h0,        4'h0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 0, 1, 32'hFC,  32'h0F0F0F0F, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'hFC,  32'h0,        4'h0, 1, 32'h0F0F0F0F, 0));
        vecs.push_back(mk(0, 1, 1, 32'h10,  32'h01020304, 4'hF, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10,  32'h0,        4'h0, 1, 32'h01020304, 0));
        vecs.push_back(mk(1, 0, 1, 32'h0,   32'hA0A0A0A0, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 32'h4,   32'hA4A4A4A4, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 32'h8,   32'hA8A8A8A8, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, 0, 32'h4,   32'h0,        4'h0, 1, 32'hA4A4A4A4, 0));
        vecs.push_back(mk(1, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'h0,        1));
        vecs.push_back(mk(2, 0, 1, 32'h40,  32'h40404040, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(2, 0, 1, 32'h44,  32'h44444444, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(2, 1, 0, 32'h40,  32'h0,        4'h0, 1, 32'h40404040, 0));

        foreach (vecs[k]) begin
            access(vecs[k].dut, vecs[k].rd, vecs[k].wr, vecs[k].a, vecs[k].wd, vecs[k].be, nb, gr, ge);
            check($sformatf("vec%0d busy cycles", k), 32'(nb), 32'(lat_of(vecs[k].dut)));
            check($sformatf("vec%0d error", k), 32'(ge), 32'(vecs[k].exp_err));
            if (vecs[k].chk_rd) begin
                exp_q.push_back(vecs[k].exp_rd);
                check($sformatf("vec%0d rdata", k), gr, exp_q.pop_front());
            end
        end

        // zero latency: held read over consecutive words, no bubbles
        ren_s[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_s[1] = 32'(i * 4);
            @(negedge CLK);
            check($sformatf("lat0 stream busy %0d", i), 32'(busy_s[1]), 32'd0);
            exp_q.push_back((i == 0) ? 32'hA0A0A0A0 : (i == 1) ? 32'hA4A4A4A4 : 32'hA8A8A8A8);
            check($sformatf("lat0 stream rdata %0d", i), rdata_s[1], exp_q.pop_front());
            @(posedge CLK); #1;
        end
        ren_s[1] = 1'b0;

        // latency 3: address changes in cycle 1, completion expected in cycle 4
        ren_s[2] = 1'b1; addr_s[2] = 32'h40;
        @(negedge CLK);
        check("lat3 restart busy c0", 32'(busy_s[2]), 32'd1);
        @(posedge CLK); #1;
        addr_s[2] = 32'h44;
        comp = -1;
        for (int c = 1; c <= 10 && comp < 0; c++) begin
            @(negedge CLK);
            if (!busy_s[2]) begin
                comp = c;
                gr   = rdata_s[2];
            end
        end
        check("lat3 restart completion cycle", 32'(comp), 32'd4);
        check("lat3 restart rdata", gr, 32'h44444444);
        @(posedge CLK); #1;
        ren_s[2] = 1'b0;
        @(posedge CLK); #1;

        // write withdrawn in WAIT: no completion, no write
        wen_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = 32'h55555555; be_s[0] = 4'hF;
        @(negedge CLK);
        check("withdraw busy c0", 32'(busy_s[0]), 32'd1);
        @(posedge CLK); #1;
        wen_s[0] = 1'b0;
        @(negedge CLK);
        check("withdraw busy c1", 32'(busy_s[0]), 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("withdraw busy c2", 32'(busy_s[0]), 32'd1);
        check("withdraw state idle", 32'(dbg_s[0]), 32'd0);
        @(posedge CLK); #1;
        access(0, 1, 0, 32'h10, 32'h0, 4'h0, nb, gr, ge);
        check("withdraw readback", gr, 32'h01020304);

        // reset during WAIT of a write to 0x30
        wen_s[0] = 1'b1; addr_s[0] = 32'h30; wdata_s[0] = 32'hBAD0BAD0; be_s[0] = 4'hF;
        @(posedge CLK); #1;
        check("mid-reset state wait", 32'(dbg_s[0]), 32'd1);
        nRST = 1'b0;
        #1;
        check("mid-reset busy", 32'(busy_s[0]), 32'd1);
        check("mid-reset rdata", rdata_s[0], 32'd0);
        check("mid-reset error", 32'(error_s[0]), 32'd0);
        check("mid-reset state", 32'(dbg_s[0]), 32'd0);
        wen_s[0] = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        access(0, 1, 0, 32'h30, 32'h0, 4'h0, nb, gr, ge);
        check("post-reset busy cycles", 32'(nb), 32'd2);
        check("post-reset old value", gr, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
